// File: rtl/te_sync_scheduler.sv
// Sync-packet scheduler for the trace encoder: decides when a PROGTRACESYNC is
// requested and with which cause, from trace-control events and a periodic counter.
module te_sync_scheduler #(
    parameter int PERIODIC_SYNC_COUNT_WIDTH = 20,
    parameter int IRETIRE_WIDTH             = 3
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 trace_en,
    input  logic [1:0]                           sync_mode,
    input  logic [PERIODIC_SYNC_COUNT_WIDTH-1:0] sync_period,
    input  logic                                 pkt_sent,
    input  logic [IRETIRE_WIDTH-1:0]             iretire_cnt,
    input  logic                                 exit_debug,
    input  logic                                 fifo_ovf_restart,
    input  logic                                 ext_trig,
    output logic                                 sync_req,
    output logic [3:0]                           sync_cause,
    input  logic                                 sync_ack,
    output logic [PERIODIC_SYNC_COUNT_WIDTH-1:0] sync_cnt
);

    localparam int PSW = PERIODIC_SYNC_COUNT_WIDTH;

    typedef logic [PSW:0] wide_t;

    typedef enum logic [1:0] {
        SYNC_OFF      = 2'd0,
        PKT_COUNT     = 2'd1,
        CYCLE_COUNT   = 2'd2,
        IRETIRE_COUNT = 2'd3
    } inst_sync_mode_e;

    typedef enum logic [3:0] {
        CAUSE_EXT_TRIG   = 4'h0,
        CAUSE_EXIT_RESET = 4'h1,
        CAUSE_PERIODIC   = 4'h2,
        CAUSE_EXIT_DEBUG = 4'h3,
        CAUSE_TRACE_EN   = 4'h5,
        CAUSE_FIFO_OVF   = 4'h7
    } sync_cause_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PEND
    } state_e;

    state_e          state;
    sync_cause_e     cause_q;
    inst_sync_mode_e mode_q;
    logic            rst_flag;
    logic            pend_rst, pend_en, pend_dbg, pend_ovf, pend_trg, pend_per;

    wide_t           inc;
    wide_t           sum;
    logic [PSW-1:0]  next_cnt;
    logic            mode_changed;
    logic            per_hit;
    logic            nx_dbg, nx_ovf, nx_trg, nx_per;
    logic            any_pend;
    sync_cause_e     cause_sel;

    assign sync_cause = cause_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        inc          = '0;
        mode_changed = (inst_sync_mode_e'(sync_mode) != mode_q);
        case (inst_sync_mode_e'(sync_mode))
            PKT_COUNT:     inc = wide_t'(pkt_sent);
            CYCLE_COUNT:   inc = wide_t'(1);
            IRETIRE_COUNT: inc = wide_t'(iretire_cnt);
            default:       inc = '0;
        endcase

        // One extra bit of headroom lets the counter saturate instead of wrapping.
        sum = {1'b0, sync_cnt} + inc;
        if (mode_changed)
            next_cnt = '0;
        else if (sum[PSW])
            next_cnt = '1;
        else
            next_cnt = sum[PSW-1:0];

        per_hit = (inst_sync_mode_e'(sync_mode) != SYNC_OFF) && (sync_period != '0)
                  && (next_cnt >= sync_period);

        nx_dbg   = pend_dbg | exit_debug;
        nx_ovf   = pend_ovf | fifo_ovf_restart;
        nx_trg   = pend_trg | ext_trig;
        nx_per   = pend_per | per_hit;
        any_pend = pend_rst | pend_en | nx_dbg | nx_ovf | nx_trg | nx_per;

        if (pend_rst)    cause_sel = CAUSE_EXIT_RESET;
        else if (pend_en) cause_sel = CAUSE_TRACE_EN;
        else if (nx_dbg) cause_sel = CAUSE_EXIT_DEBUG;
        else if (nx_ovf) cause_sel = CAUSE_FIFO_OVF;
        else if (nx_trg) cause_sel = CAUSE_EXT_TRIG;
        else             cause_sel = CAUSE_PERIODIC;
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            sync_req <= 1'b0;
            cause_q  <= CAUSE_EXT_TRIG;
            sync_cnt <= '0;
            mode_q   <= SYNC_OFF;
            rst_flag <= 1'b1;
            pend_rst <= 1'b0;
            pend_en  <= 1'b0;
            pend_dbg <= 1'b0;
            pend_ovf <= 1'b0;
            pend_trg <= 1'b0;
            pend_per <= 1'b0;
        end else begin
            mode_q <= inst_sync_mode_e'(sync_mode);
            if (!trace_en) begin
                // Disabling trace aborts any outstanding request without waiting for ack.
                state    <= S_IDLE;
                sync_req <= 1'b0;
                sync_cnt <= '0;
                pend_rst <= 1'b0;
                pend_en  <= 1'b0;
                pend_dbg <= 1'b0;
                pend_ovf <= 1'b0;
                pend_trg <= 1'b0;
                pend_per <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        // Enabling always creates a cause, so the request goes out next cycle.
                        state    <= S_PEND;
                        sync_req <= 1'b1;
                        if (rst_flag) begin
                            rst_flag <= 1'b0;
                            pend_rst <= 1'b1;
                            cause_q  <= CAUSE_EXIT_RESET;
                        end else begin
                            pend_en  <= 1'b1;
                            cause_q  <= CAUSE_TRACE_EN;
                        end
                    end
                    S_RUN: begin
                        sync_cnt <= next_cnt;
                        pend_dbg <= nx_dbg;
                        pend_ovf <= nx_ovf;
                        pend_trg <= nx_trg;
                        pend_per <= nx_per;
                        if (any_pend) begin
                            state    <= S_PEND;
                            sync_req <= 1'b1;
                            cause_q  <= cause_sel;
                        end
                    end
                    S_PEND: begin
                        if (sync_ack) begin
                            // One sync covers every cause; pulses arriving now still count.
                            state    <= S_RUN;
                            sync_req <= 1'b0;
                            sync_cnt <= '0;
                            pend_rst <= 1'b0;
                            pend_en  <= 1'b0;
                            pend_dbg <= exit_debug;
                            pend_ovf <= fifo_ovf_restart;
                            pend_trg <= ext_trig;
                            pend_per <= 1'b0;
                        end else begin
                            sync_cnt <= next_cnt;
                            pend_dbg <= nx_dbg;
                            pend_ovf <= nx_ovf;
                            pend_trg <= nx_trg;
                            pend_per <= nx_per;
                        end
                    end
                    default: begin
                        state    <= S_IDLE;
                        sync_req <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
